// File: rtl/posit_pkg.sv
// Shared es=2 posit constants and width helpers for the encoder datapath.
package posit_pkg;

    localparam int ES = 2;

    function automatic int log2c(input int n);
        if (n == 8)  return 3;
        if (n == 16) return 4;
        if (n == 32) return 5;
        return 6;
    endfunction

    // Scale factor is {k[LN:0] signed, exp[ES-1:0]}.
    function automatic int sf_w(input int n);
        return log2c(n) + 1 + ES;
    endfunction

    function automatic int frac_w(input int n);
        return n - 5;
    endfunction

    // Regime run length is held with the same width as k.
    function automatic int len_w(input int n);
        return log2c(n) + 1;
    endfunction

endpackage

// File: rtl/posit_regime_pack.sv
// Combinational body builder: regime run, terminator, exponent and fraction,
// left-aligned into N-1 bits with the first dropped bit and OR of the rest.
module posit_regime_pack
    import posit_pkg::*;
#(
    parameter  int N      = 8,
    localparam int LEN_W  = len_w(N),
    localparam int FRAC_W = frac_w(N)
) (
    input  logic              rc,
    input  logic [LEN_W-1:0]  len,
    input  logic [ES-1:0]     e,
    input  logic [FRAC_W-1:0] frac,
    output logic [N-2:0]      body,
    output logic              guard,
    output logic              sticky
);

    localparam int DROP_W = N - 2;
    localparam int FULL_W = (N - 1) + DROP_W;
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(N - 2);

    logic [FULL_W-1:0] full;
    logic [FULL_W-1:0] shifted;
    logic [LEN_W-1:0]  shamt;

    // Start from the longest possible run and shift out the surplus regime bits.
    assign full    = {{(N-1){rc}}, ~rc, e, frac};
    assign shamt   = LEN_MAX - len;
    assign shifted = full << shamt;

    assign body   = shifted[FULL_W-1 -: N-1];
    assign guard  = shifted[DROP_W-1];
    assign sticky = |shifted[DROP_W-2:0];

endmodule

// File: rtl/posit_encoder_pipe.sv
// Two-stage posit (es=2) field encoder with valid/ready on both sides.
// Define POSIT_ENC_ROUND_EN for round-to-nearest-even; default truncates.
module posit_encoder_pipe
    import posit_pkg::*;
#(
    parameter  int N      = 8,
    localparam int LN     = log2c(N),
    localparam int SF_W   = sf_w(N),
    localparam int FRAC_W = frac_w(N),
    localparam int LEN_W  = len_w(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              Sign,
    input  logic [SF_W-1:0]   SF,
    input  logic [FRAC_W-1:0] Frac,
    input  logic              NZN,
    input  logic              Guard,
    input  logic              Sticky,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N-1:0]      X
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(N - 2);

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        return (len > LEN_MAX) ? LEN_MAX : len;
    endfunction

    // A nonzero input must never collapse onto the zero/NaR encodings.
    function automatic logic [N-2:0] sat_nonzero(input logic [N-2:0] body);
        return (body == '0) ? {{(N-2){1'b0}}, 1'b1} : body;
    endfunction

    function automatic logic [N-2:0] round_rne(
        input logic [N-2:0] body,
        input logic         nodrop,
        input logic         g_port,
        input logic         s_port,
        input logic         g_drop,
        input logic         s_drop
    );
        logic g;
        logic s;
        g = nodrop ? g_port : g_drop;
        s = nodrop ? s_port : (s_drop | g_port | s_port);
        if (g && (s || body[0]) && !(&body)) return body + 1'b1;
        return body;
    endfunction

    logic              vld_p1;
    logic              vld_p2;
    logic              adv_p1;
    logic              adv_p2;

    logic signed [LN:0] k_p0;
    logic [ES-1:0]      exp_p0;
    logic               r_p0;
    logic [LEN_W-1:0]   len_p0;

    logic              sign_p1;
    logic              nzn_p1;
    logic              rc_p1;
    logic [LEN_W-1:0]  len_p1;
    logic [ES-1:0]     e_p1;
    logic [FRAC_W-1:0] frac_p1;
    logic              guard_p1;
    logic              sticky_p1;

    logic [N-2:0]      body_raw;
    logic              g_drop;
    logic              s_drop;
    logic [N-2:0]      body_fin;
    logic [N-1:0]      x_next;
    logic [N-1:0]      x_p2;

    assign adv_p2    = out_ready | ~vld_p2;
    assign adv_p1    = adv_p2 | ~vld_p1;
    assign in_ready  = adv_p1;
    assign out_valid = vld_p2;
    assign X         = x_p2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (adv_p1) vld_p1 <= in_valid;
            if (adv_p2) vld_p2 <= vld_p1;
        end
    end

    // ---- stage 0 -> 1: regime direction, run length and sign-folded fields
    assign k_p0   = SF[SF_W-1:ES];
    assign exp_p0 = SF[ES-1:0];
    assign r_p0   = ~k_p0[LN];

    always_comb begin
        len_p0 = clamp_len(r_p0 ? $unsigned(k_p0) : $unsigned(~k_p0));
    end

    always_ff @(posedge clk) begin
        if (adv_p1 && in_valid) begin
            sign_p1   <= Sign;
            nzn_p1    <= NZN;
            rc_p1     <= r_p0 ^ Sign;
            len_p1    <= len_p0;
            e_p1      <= exp_p0 ^ {ES{Sign}};
            frac_p1   <= Frac;
            guard_p1  <= Guard;
            sticky_p1 <= Sticky;
        end
    end

    // ---- stage 1 -> 2: pack body, optional rounding, result register
    posit_regime_pack #(.N(N)) u_pack (
        .rc     (rc_p1),
        .len    (len_p1),
        .e      (e_p1),
        .frac   (frac_p1),
        .body   (body_raw),
        .guard  (g_drop),
        .sticky (s_drop)
    );

`ifdef POSIT_ENC_ROUND_EN
    always_comb begin
        body_fin = sat_nonzero(round_rne(body_raw, (len_p1 == '0), guard_p1,
                                         sticky_p1, g_drop, s_drop));
    end
`else
    logic unused_rnd;
    assign unused_rnd = ^{guard_p1, sticky_p1, g_drop, s_drop};

    always_comb begin
        body_fin = sat_nonzero(body_raw);
    end
`endif

    always_comb begin
        x_next = nzn_p1 ? {sign_p1, body_fin} : {sign_p1, {(N-1){1'b0}}};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_p2 <= '0;
        end else if (adv_p2 && vld_p1) begin
            x_p2 <= x_next;
        end
    end

endmodule

// File: doc/posit_encoder_pipe.md
Name: posit_encoder_pipe

Overview:
- Pipelined posit encoder: packs {Sign, SF, Frac, NZN} fields back into an N-bit posit word (es=2).
- Exact inverse of the team's posit field decoder; sits at the MAC output, after normalisation, before the result register/bus.
- Two register stages with valid/ready handshake on both sides and full throughput.

Parameters:
- N, 8, posit width in bits (8, 16, 32 or 64).
- LN (localparam), log2c(N) with 8→3, 16→4, 32→5, else 6; SF width is LN+3, Frac width is N-5.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input fields valid.
- in_ready  out  1  encoder can accept this cycle.
- Sign  in  1  posit sign.
- SF  in  LN+3  scale factor {k[LN:0] signed, exp[1:0]}.
- Frac  in  N-5  fraction bits, raw (not sign-adjusted).
- NZN  in  1  0 = zero/NaR.
- Guard  in  1  rounding guard bit (used only with macro).
- Sticky  in  1  rounding sticky bit (used only with macro).
- out_valid  out  1  X valid.
- out_ready  in  1  downstream accepts X.
- X  out  N  encoded posit.

Behaviour:
- Reset: out_valid=0, X=0, in_ready=1, both stage valids=0. Reset mid-operation discards in-flight words; nothing is emitted after release until new inputs are accepted.
- Transfer occurs when valid&ready are both high on an edge. Stage 2 advances when out_ready or stage 2 is empty. Stage 1 advances when stage 2 advances or stage 1 is empty. in_ready = stage-1 advance condition, with no combinational path from in_valid.
- Latency: 2 cycles from input accept to out_valid. One word per cycle when out_ready is held high. Order is preserved. Holding out_ready low accepts at most 2 words, then in_ready=0. X and out_valid stay stable while stalled.
- Stage 1 (register):
  - r = ~k[LN].
  - len = r ? k : ~k, unsigned; clamp len to N-2.
  - rc = r ^ Sign.
  - e = exp ^ {Sign,Sign}.
  - Register Sign, NZN, rc, len, e, Frac, Guard, Sticky.
- Stage 2 (register):
  - Body = (len+1) copies of rc, then ~rc, then e, then Frac.
  - Left-align the body into N-1 bits; bits beyond N-1 are dropped.
  - X = {Sign, body}.
- Saturation: len=N-2 gives body all rc (maxpos/minpos patterns). Never produces NaR or zero from NZN=1.
- NZN=0: X = {Sign, (N-1) zeros}, i.e. 0x00 or 0x80 for N=8. Other fields are ignored.
- Round-trip: for every N-bit X0, feeding the decoder's outputs of X0 into this block yields X0.

Optional Feature:
- Macro POSIT_ENC_ROUND_EN.
- Defined: round-to-nearest-even on the N-1-bit body.
  - Guard is the first dropped body bit, or the Guard port if no body bit is dropped.
  - Sticky is the OR of the remaining dropped bits, the Guard port (when a body bit was dropped), and the Sticky port.
  - The body is incremented as unsigned when guard & (sticky | body lsb).
  - Increment saturates: an all-ones body is not incremented; an all-zeros body is never produced from NZN=1.
  - Latency is unchanged (the increment is in stage 2).
- Undefined: truncation. Guard and Sticky ports exist but are ignored.

Decomposition:
- posit_pkg holds: the log2c function, SF/Frac/len width constants, and the es=2 constant.
- One natural sub-module, posit_regime_pack (combinational). It takes rc, len, e, Frac and returns the N-1-bit body plus dropped guard/sticky. Stage 2 instantiates it.

Test Plan:
- N=8, Sign=0, SF=6'b000000, Frac=000, NZN=1 → X=0x40 two cycles after accept.
- Sign=0, SF=6'b111100 (k=-1), Frac=000 → X=0x20. Sign=1, SF=6'b111111, Frac=000 → X=0xC0.
- NZN=0 with Sign=0 → 0x00; Sign=1 → 0x80. Sign=0, SF=6'b011111, Frac=111 → 0x7F (saturated).
- Exhaustive round-trip: drive decoder outputs for all 256 X0 back-to-back with out_ready=1 → X==X0 for every word, one per cycle.
- Backpressure: send 5 words, hold out_ready=0 for 4 cycles → in_ready falls after 2 accepts; all 5 emerge in order, unchanged.
- Assert rst while 2 words are in flight → out_valid=0 immediately and stays 0; the next accepted word emerges 2 cycles later with correct value.
